// File: rtl/gcd_stream_ctrl_pkg.sv
// rtl/gcd_stream_ctrl_pkg.sv - shared definitions for the GCD stream sequencer and core
package gcd_stream_ctrl_pkg;

  localparam int GCD_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_BUSY = 2'd2,
    S_HOLD = 2'd3
  } gcd_state_t;

  // Operand pairs containing a zero never converge in the subtractive core.
  function automatic logic is_bypass(input logic [GCD_WIDTH-1:0] a, input logic [GCD_WIDTH-1:0] b);
    return (a == '0) || (b == '0);
  endfunction

endpackage

// File: rtl/gcd_core.sv
// rtl/gcd_core.sv - subtractive GCD core, instantiated beside the sequencer by the parent
module gcd_core
  import gcd_stream_ctrl_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;

  // Load on load_n low, otherwise subtract the smaller operand from the larger.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_a <= '0;
      r_b <= '0;
    end else if (!load_n) begin
      r_a <= a;
      r_b <= b;
    end else if (r_a > r_b) begin
      r_a <= r_a - r_b;
    end else if (r_b > r_a) begin
      r_b <= r_b - r_a;
    end
  end

  // Done is combinational on equality, so it reads 1 straight out of reset.
  assign done = (r_a == r_b);
  assign y    = r_a;

endmodule

// File: rtl/gcd_stream_ctrl.sv
// rtl/gcd_stream_ctrl.sv - stream sequencer driving the subtractive GCD core
module gcd_stream_ctrl
  import gcd_stream_ctrl_pkg::*;
#(
  parameter int WIDTH   = GCD_WIDTH,
  parameter int CNT_W   = 10,
  parameter int MAX_CYC = 300
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             core_load_n,
  output logic [WIDTH-1:0] core_a,
  output logic [WIDTH-1:0] core_b,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [CNT_W-1:0] out_cycles,
  output logic             out_err,
  output logic             busy
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CYC);

  gcd_state_t       r_state;
  gcd_state_t       w_next;
  logic             r_load_n;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_y;
  logic [CNT_W-1:0] r_cycles;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_bypass;
  logic             w_timeout;

  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_bypass  = is_bypass(in_a, in_b);
  assign w_timeout = (w_cnt_inc == MAX_C);

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; done wins over timeout because both lead to HOLD.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_next = w_bypass ? S_HOLD : S_LOAD;
      S_LOAD: w_next = S_BUSY;
      S_BUSY: if (core_done || w_timeout) w_next = S_HOLD;
      S_HOLD: if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand, load strobe, cycle counter and result registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_load_n <= 1'b1;
      r_a      <= '0;
      r_b      <= '0;
      r_y      <= '0;
      r_cycles <= '0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a <= in_a;
            r_b <= in_b;
            if (w_bypass) begin
              r_y      <= in_a | in_b;
              r_cycles <= '0;
              r_err    <= 1'b0;
            end else begin
              r_load_n <= 1'b0;
            end
          end
        end
        S_LOAD: begin
          r_load_n <= 1'b1;
          r_cnt    <= '0;
        end
        S_BUSY: begin
          if (r_cnt != MAX_C) r_cnt <= w_cnt_inc;
          if (core_done || w_timeout) begin
            r_y      <= core_y;
            r_cycles <= w_cnt_inc;
            r_err    <= !core_done;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign out_valid   = (r_state == S_HOLD);
  assign core_load_n = r_load_n;
  assign core_a      = r_a;
  assign core_b      = r_b;
  assign out_y       = r_y;
  assign out_cycles  = r_cycles;
  assign out_err     = r_err;

endmodule
